// File: rtl/isr_pkg.sv
// isr_pkg: shared state type and parameter-legality checks for the iterative square root
package isr_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} isr_state_t;
  function automatic bit width_ok(input int w);
    return (w >= 4) && (w % 2 == 0);
  endfunction
  function automatic bit bpc_ok(input int w, input int b);
    return (b == 1 || b == 2 || b == 4) && ((w / 2) % b == 0);
  endfunction
endpackage

// File: rtl/isr_step.sv
// isr_step: one combinational digit-recurrence step resolving a single root bit
module isr_step #(
  parameter int OUT_WIDTH = 32
) (
  input  logic [OUT_WIDTH+1:0] rem_in,
  input  logic [OUT_WIDTH-1:0] root_in,
  input  logic [1:0]           bits_in,
  output logic [OUT_WIDTH+1:0] rem_out,
  output logic [OUT_WIDTH-1:0] root_out
);
  logic [OUT_WIDTH+1:0] w_trial;
  logic [OUT_WIDTH+1:0] w_test;
  logic                 w_ge;
  // Bring down two radicand bits and try appending a 1 to the root
  always_comb begin
    w_trial  = (rem_in << 2) | {{OUT_WIDTH{1'b0}}, bits_in};
    w_test   = {root_in, 2'b01};
    w_ge     = w_trial >= w_test;
    rem_out  = w_ge ? w_trial - w_test : w_trial;
    root_out = (root_in << 1) | {{(OUT_WIDTH-1){1'b0}}, w_ge};
  end
endmodule

// File: rtl/isr_iter.sv
// isr_iter: iterative integer square root, BITS_PER_CYCLE root bits per clock, start/busy/done handshake
module isr_iter import isr_pkg::*; #(
  parameter int IN_WIDTH       = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   value,
  output logic                  busy,
  output logic                  done,
  output logic [IN_WIDTH/2-1:0] result,
  output logic [IN_WIDTH/2:0]   remainder
);
  localparam int OUT_WIDTH = IN_WIDTH / 2;
  localparam int N         = OUT_WIDTH / BITS_PER_CYCLE;
  localparam int CW        = $clog2(N + 1);

  if (!width_ok(IN_WIDTH)) begin : g_bad_width
    $error("isr_iter: IN_WIDTH must be even and >= 4");
  end
  if (!bpc_ok(IN_WIDTH, BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("isr_iter: BITS_PER_CYCLE must be 1, 2 or 4 and divide IN_WIDTH/2");
  end

  isr_state_t           r_state;
  isr_state_t           w_state_nxt;
  logic [IN_WIDTH-1:0]  r_rad;
  logic [OUT_WIDTH-1:0] r_root;
  logic [OUT_WIDTH+1:0] r_rem;
  logic [CW-1:0]        r_cnt;
  logic [OUT_WIDTH-1:0] r_result;
  logic [OUT_WIDTH:0]   r_remainder;
  logic [OUT_WIDTH+1:0] w_rem  [0:BITS_PER_CYCLE];
  logic [OUT_WIDTH-1:0] w_root [0:BITS_PER_CYCLE];
  logic                 w_accept;
  logic                 w_finish;
  logic                 w_unused_top;

  assign w_rem[0]  = r_rem;
  assign w_root[0] = r_root;
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    isr_step #(.OUT_WIDTH(OUT_WIDTH)) u_step (
      .rem_in  (w_rem[g]),
      .root_in (w_root[g]),
      .bits_in (r_rad[IN_WIDTH-1-2*g -: 2]),
      .rem_out (w_rem[g+1]),
      .root_out(w_root[g+1])
    );
  end

  // The final remainder never exceeds 2*root, so its top internal bit is always zero
  assign w_unused_top = w_rem[BITS_PER_CYCLE][OUT_WIDTH+1];
  assign result       = r_result;
  assign remainder    = r_remainder;

  // Next state: accept in IDLE/DONE, finish on the last counted BUSY edge
  always_comb begin
    w_accept    = start && (r_state != BUSY);
    w_finish    = (r_state == BUSY) && (r_cnt == CW'(1));
    w_state_nxt = w_accept ? BUSY : w_finish ? DONE : r_state;
    busy        = r_state == BUSY;
    done        = r_state == DONE;
  end

  // State register
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;

  // Recurrence datapath: load on accept, advance BITS_PER_CYCLE steps per BUSY edge
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_rad  <= '0;
      r_root <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_rad  <= value;
      r_root <= '0;
      r_rem  <= '0;
      r_cnt  <= CW'(N);
    end else if (r_state == BUSY) begin
      r_rad  <= r_rad << (2 * BITS_PER_CYCLE);
      r_root <= w_root[BITS_PER_CYCLE];
      r_rem  <= w_rem[BITS_PER_CYCLE];
      r_cnt  <= r_cnt - 1'b1;
    end

  // Result registers update only at completion and otherwise hold
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_result    <= '0;
      r_remainder <= '0;
    end else if (w_finish) begin
      r_result    <= w_root[BITS_PER_CYCLE];
      r_remainder <= w_rem[BITS_PER_CYCLE][OUT_WIDTH:0];
    end
endmodule
